// File: rtl/plot_shadow_buffer.sv
// Shadow frame buffer between the plot sources and vga_adapter: forwards accepted
// writes one cycle later, keeps a readable 160x120 copy, and runs a full-screen clear.
module plot_shadow_buffer #(
   parameter int unsigned    H_RES        = 160,
   parameter int unsigned    V_RES        = 120,
   parameter int unsigned    XW           = 8,
   parameter int unsigned    YW           = 7,
   parameter int unsigned    CW           = 3,
   parameter logic [CW-1:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [CW-1:0] colour,
   input  logic          plot,
   output logic          plot_ready,
   input  logic          clear,
   output logic          busy,
   input  logic          rd_req,
   input  logic [XW-1:0] rd_x,
   input  logic [YW-1:0] rd_y,
   output logic          rd_valid,
   output logic [CW-1:0] rd_colour,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [CW-1:0] vga_colour,
   output logic          vga_plot
);

   localparam int unsigned   N_PIX = H_RES * V_RES;
   localparam int unsigned   AW    = $clog2(N_PIX);
   localparam logic [XW-1:0] X_MAX = XW'(H_RES);
   localparam logic [YW-1:0] Y_MAX = YW'(V_RES);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t        state;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [CW-1:0] mem [N_PIX];

   logic          plot_in, rd_in, plot_take;
   logic          we;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [CW-1:0] wr_data;

   function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px, input logic [YW-1:0] py);
      return AW'(py) * AW'(H_RES) + AW'(px);
   endfunction

   assign busy       = (state == CLEAR);
   assign plot_ready = (state == IDLE);

   always_comb begin
      plot_in   = (x < X_MAX) && (y < Y_MAX);
      rd_in     = (rd_x < X_MAX) && (rd_y < Y_MAX);
      // clear in the same cycle pre-empts both the plot and the read
      plot_take = (state == IDLE) && !clear && plot && plot_in;
      rd_addr   = pix_addr(rd_x, rd_y);
      we        = 1'b0;
      wr_addr   = pix_addr(x, y);
      wr_data   = colour;
      if (state == CLEAR) begin
         we      = 1'b1;
         wr_addr = pix_addr(cx, cy);
         wr_data = CLEAR_COLOUR;
      end else if (plot_take) begin
         we      = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= CLEAR;
         cx         <= '0;
         cy         <= '0;
         rd_valid   <= 1'b0;
         rd_colour  <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         vga_plot <= 1'b0;
         rd_valid <= 1'b0;
         case (state)
            CLEAR: begin
               vga_x      <= cx;
               vga_y      <= cy;
               vga_colour <= CLEAR_COLOUR;
               vga_plot   <= 1'b1;
               if (cx == X_MAX - 1'b1) begin
                  cx <= '0;
                  if (cy == Y_MAX - 1'b1) begin
                     cy    <= '0;
                     state <= IDLE;
                  end else begin
                     cy <= cy + 1'b1;
                  end
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            IDLE: begin
               if (clear) begin
                  state <= CLEAR;
                  cx    <= '0;
                  cy    <= '0;
               end else begin
                  if (plot_take) begin
                     vga_x      <= x;
                     vga_y      <= y;
                     vga_colour <= colour;
                     vga_plot   <= 1'b1;
                  end
                  // read-first: a same-cycle write to this address is not yet visible
                  if (rd_req) begin
                     rd_valid  <= 1'b1;
                     rd_colour <= rd_in ? mem[rd_addr] : '0;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_plot_shadow_buffer.sv
// Directed self-checking bench for plot_shadow_buffer: clear sequencing, plot
// forwarding, read port behaviour, priority rules and mid-clear reset.
module tb_plot_shadow_buffer;

   logic       CLOCK_50 = 1'b0;
   logic       resetn   = 1'b0;
   logic [7:0] x = '0, rd_x = '0, vga_x;
   logic [6:0] y = '0, rd_y = '0, vga_y;
   logic [2:0] colour = '0, rd_colour, vga_colour;
   logic       plot = 1'b0, clear = 1'b0, rd_req = 1'b0;
   logic       plot_ready, busy, rd_valid, vga_plot;

   int unsigned errors = 0;
   int unsigned checks = 0;

   plot_shadow_buffer #(.H_RES(160), .V_RES(120), .XW(8), .YW(7), .CW(3), .CLEAR_COLOUR(3'b000)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .x(x), .y(y), .colour(colour), .plot(plot), .plot_ready(plot_ready),
      .clear(clear), .busy(busy),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_colour(rd_colour),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      plot = 1'b1; x = px; y = py; colour = pc;
   endtask

   task automatic drive_rd(input logic [7:0] px, input logic [6:0] py);
      rd_req = 1'b1; rd_x = px; rd_y = py;
   endtask

   task automatic idle_inputs();
      plot = 1'b0; rd_req = 1'b0; clear = 1'b0;
   endtask

   // Called one sample after the DUT has entered CLEAR; follows it until busy drops.
   task automatic run_clear(input string tag);
      int unsigned cyc = 0, plots = 0, seq_bad = 0, rdv = 0;
      int unsigned ex = 0, ey = 0, lx = 999, ly = 999;
      do begin
         step();
         cyc++;
         if (vga_plot === 1'b1) begin
            if (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'd0) seq_bad++;
            plots++;
            lx = vga_x;
            ly = vga_y;
            if (ex == 159) begin ex = 0; ey++; end else ex++;
         end
         if (rd_valid === 1'b1) rdv++;
      end while (busy === 1'b1 && cyc < 20000);
      chk({tag, "_cycles"}, cyc, 19200);
      chk({tag, "_plots"}, plots, 19200);
      chk({tag, "_order"}, seq_bad, 0);
      chk({tag, "_last_x"}, lx, 159);
      chk({tag, "_last_y"}, ly, 119);
      chk({tag, "_ready"}, plot_ready, 1);
      chk({tag, "_rd_dropped"}, rdv, 0);
   endtask

   initial begin
      // reset state
      step(); step();
      chk("rst_busy", busy, 1);
      chk("rst_ready", plot_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_colour", rd_colour, 0);
      chk("rst_vga_plot", vga_plot, 0);
      chk("rst_vga_xy", {vga_x, vga_y, vga_colour}, 0);
      resetn = 1'b1;
      run_clear("clr0");

      // plot then read back
      drive_plot(8'd10, 7'd20, 3'd5);
      step();
      idle_inputs();
      chk("fwd_x", vga_x, 10);
      chk("fwd_y", vga_y, 20);
      chk("fwd_colour", vga_colour, 5);
      chk("fwd_plot", vga_plot, 1);
      drive_rd(8'd10, 7'd20);
      step();
      idle_inputs();
      chk("rd_valid", rd_valid, 1);
      chk("rd_colour", rd_colour, 5);
      chk("fwd_plot_drop", vga_plot, 0);
      step();
      chk("rd_valid_pulse", rd_valid, 0);
      chk("rd_colour_hold", rd_colour, 5);
      drive_rd(8'd11, 7'd20);
      step();
      idle_inputs();
      chk("rd_neighbour", rd_colour, 0);

      // out-of-range plots and aliasing, back-to-back reads
      drive_plot(8'd160, 7'd5, 3'd7);
      step();
      chk("oor_x_plot", vga_plot, 0);
      drive_plot(8'd5, 7'd120, 3'd7);
      step();
      plot = 1'b0;
      chk("oor_y_plot", vga_plot, 0);
      drive_rd(8'd159, 7'd5);
      step();
      chk("alias_a_valid", rd_valid, 1);
      chk("alias_a", rd_colour, 0);
      drive_rd(8'd0, 7'd6);
      step();
      idle_inputs();
      chk("alias_b_valid", rd_valid, 1);
      chk("alias_b", rd_colour, 0);
      drive_plot(8'd0, 7'd6, 3'd4);
      step();
      idle_inputs();
      drive_rd(8'd0, 7'd6);
      step();
      chk("rd_06", rd_colour, 4);
      drive_rd(8'd160, 7'd5);
      step();
      idle_inputs();
      chk("oor_rd_valid", rd_valid, 1);
      chk("oor_rd_colour", rd_colour, 0);

      // same-cycle write and read: read-first
      drive_plot(8'd3, 7'd3, 3'd6);
      step();
      drive_plot(8'd3, 7'd3, 3'd2);
      drive_rd(8'd3, 7'd3);
      step();
      plot = 1'b0;
      chk("rf_old", rd_colour, 6);
      chk("rf_fwd", vga_colour, 2);
      step();
      idle_inputs();
      chk("rf_new", rd_colour, 2);

      // clear beats plot and read in the same cycle; reads dropped while busy
      clear = 1'b1;
      drive_plot(8'd1, 7'd1, 3'd7);
      drive_rd(8'd3, 7'd3);
      step();
      clear = 1'b0; plot = 1'b0;
      chk("clr_busy", busy, 1);
      chk("clr_plot_dropped", vga_plot, 0);
      chk("clr_rd_dropped", rd_valid, 0);
      run_clear("clr1");
      idle_inputs();
      drive_rd(8'd1, 7'd1);
      step();
      chk("post_clr_11", rd_colour, 0);
      drive_rd(8'd3, 7'd3);
      step();
      idle_inputs();
      chk("post_clr_33", rd_colour, 0);

      // reset in the middle of a clear
      drive_plot(8'd10, 7'd20, 3'd5);
      step();
      idle_inputs();
      drive_rd(8'd10, 7'd20);
      step();
      idle_inputs();
      chk("pre_rst_rd", rd_colour, 5);
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 5000; i++) step();
      chk("mid_clr_x", vga_x, 39);
      chk("mid_clr_y", vga_y, 31);
      chk("mid_clr_rd_hold", rd_colour, 5);
      resetn = 1'b0;
      #1;
      chk("async_vga_plot", vga_plot, 0);
      chk("async_vga_xy", {vga_x, vga_y}, 0);
      chk("async_rd_colour", rd_colour, 0);
      chk("async_busy", {busy, plot_ready}, 2'b10);
      step(); step();
      resetn = 1'b1;
      run_clear("clr2");
      drive_rd(8'd10, 7'd20);
      step();
      idle_inputs();
      chk("post_rst_rd", rd_colour, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
